// File: rtl/ytydla_cacc_psum.sv
// CACC partial-sum accumulator: bias + N aggregations, saturate, FWFT result FIFO.
// Build option: define YTYDLA_CACC_RELU_EN to zero negative results before the FIFO.
`ifndef YTYDLA_DATA_LENGTH
`define YTYDLA_DATA_LENGTH 16
`endif

module ytydla_cacc_psum #(
   parameter int DATA_W     = `YTYDLA_DATA_LENGTH,
   parameter int ACC_W      = DATA_W + 8,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              ytydla_core_clk,
   input  logic              ytydla_core_rst_n,
   input  logic              op_start,
   input  logic [CNT_W-1:0]  cfg_accu_num,
   input  logic [CNT_W-1:0]  cfg_out_num,
   input  logic [DATA_W-1:0] cfg_bias,
   input  logic              accu2cacc_valid,
   input  logic [DATA_W-1:0] accu2cacc_data,
   output logic              cacc2cmac_stall,
   output logic              cacc2wb_valid,
   output logic [DATA_W-1:0] cacc2wb_data,
   input  logic              wb2cacc_ready,
   output logic              cacc_busy,
   output logic              cacc_op_done,
   output logic              cacc_err_ovf
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic signed [ACC_W-1:0] SMAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCU  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]  accu_num_q, accu_num_d;
   logic [CNT_W-1:0]  out_num_q, out_num_d;
   logic [DATA_W-1:0] bias_q, bias_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  accu_cnt_q, accu_cnt_d;
   logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic              ovf_q, ovf_d;
   logic              stall_q;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic signed [ACC_W-1:0] acc_next;
   logic [DATA_W-1:0]       sat_val;
   logic [DATA_W-1:0]       push_val;
   logic                    push, pop, wr_en;

   assign acc_next = acc_q +
      {{(ACC_W-DATA_W){accu2cacc_data[DATA_W-1]}}, accu2cacc_data};

   always_comb begin
      sat_val = acc_next[DATA_W-1:0];
      if (acc_next > SMAX) begin
         sat_val = SMAX[DATA_W-1:0];
      end else if (acc_next < SMIN) begin
         sat_val = SMIN[DATA_W-1:0];
      end
   end

`ifdef YTYDLA_CACC_RELU_EN
   assign push_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
   assign push_val = sat_val;
`endif

   assign pop = (count_q != '0) && wb2cacc_ready;

   always_comb begin
      state_d    = state_q;
      accu_num_d = accu_num_q;
      out_num_d  = out_num_q;
      bias_d     = bias_q;
      acc_d      = acc_q;
      accu_cnt_d = accu_cnt_q;
      out_cnt_d  = out_cnt_q;
      ovf_d      = ovf_q;
      push       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (op_start) begin
               accu_num_d = (cfg_accu_num == '0) ? CNT_W'(1) : cfg_accu_num;
               out_num_d  = cfg_out_num;
               bias_d     = cfg_bias;
               acc_d      = {{(ACC_W-DATA_W){cfg_bias[DATA_W-1]}}, cfg_bias};
               accu_cnt_d = '0;
               out_cnt_d  = '0;
               ovf_d      = 1'b0;
               state_d    = (cfg_out_num == '0) ? DONE : ACCU;
            end
         end
         ACCU: begin
            if (accu2cacc_valid) begin
               if (accu_cnt_q == accu_num_q - CNT_W'(1)) begin
                  push       = 1'b1;
                  acc_d      = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
                  accu_cnt_d = '0;
                  out_cnt_d  = out_cnt_q + CNT_W'(1);
                  if (out_cnt_d == out_num_q) begin
                     state_d = FLUSH;
                  end
               end else begin
                  acc_d      = acc_next;
                  accu_cnt_d = accu_cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            if (count_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A push into a full FIFO only lands if the head leaves in the same cycle.
   always_comb begin
      wr_en    = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
      wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(wr_en) - CW'(pop);
   end

   always_ff @(posedge ytydla_core_clk) begin
      if (!ytydla_core_rst_n) begin
         state_q    <= IDLE;
         accu_num_q <= '0;
         out_num_q  <= '0;
         bias_q     <= '0;
         acc_q      <= '0;
         accu_cnt_q <= '0;
         out_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         stall_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         accu_num_q <= accu_num_d;
         out_num_q  <= out_num_d;
         bias_q     <= bias_d;
         acc_q      <= acc_d;
         accu_cnt_q <= accu_cnt_d;
         out_cnt_q  <= out_cnt_d;
         ovf_q      <= ovf_d | (push & ~wr_en);
         stall_q    <= (count_d >= CW'(FIFO_DEPTH - 1));
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge ytydla_core_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_val;
      end
   end

   assign cacc2wb_valid   = (count_q != '0);
   assign cacc2wb_data    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign cacc2cmac_stall = stall_q;
   assign cacc_busy       = (state_q == ACCU) || (state_q == FLUSH);
   assign cacc_op_done    = (state_q == DONE);
   assign cacc_err_ovf    = ovf_q;

endmodule

// File: tb/tb_ytydla_cacc_psum.sv
// Directed bench for ytydla_cacc_psum at DATA_W=16.
// Expected values are hand-computed from the accumulation rules.
`timescale 1ns/1ps

module tb_ytydla_cacc_psum;

   logic        clk;
   logic        rst_n;
   logic        op_start;
   logic [15:0] cfg_accu_num;
   logic [15:0] cfg_out_num;
   logic [15:0] cfg_bias;
   logic        in_valid;
   logic [15:0] in_data;
   logic        stall;
   logic        wb_valid;
   logic [15:0] wb_data;
   logic        wb_ready;
   logic        busy;
   logic        op_done;
   logic        err_ovf;

   int tests;
   int fails;

   ytydla_cacc_psum #(
      .DATA_W(16), .ACC_W(24), .CNT_W(16), .FIFO_DEPTH(4)
   ) dut (
      .ytydla_core_clk  (clk),
      .ytydla_core_rst_n(rst_n),
      .op_start         (op_start),
      .cfg_accu_num     (cfg_accu_num),
      .cfg_out_num      (cfg_out_num),
      .cfg_bias         (cfg_bias),
      .accu2cacc_valid  (in_valid),
      .accu2cacc_data   (in_data),
      .cacc2cmac_stall  (stall),
      .cacc2wb_valid    (wb_valid),
      .cacc2wb_data     (wb_data),
      .wb2cacc_ready    (wb_ready),
      .cacc_busy        (busy),
      .cacc_op_done     (op_done),
      .cacc_err_ovf     (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic start(input int an, input int on, input int b);
      op_start     = 1'b1;
      cfg_accu_num = 16'(an);
      cfg_out_num  = 16'(on);
      cfg_bias     = 16'(b);
      tick();
      op_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!op_done && n < 20) begin
         tick();
         n++;
      end
      chk(tag, int'(op_done), 1);
      tick();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      op_start = 1'b0;
      cfg_accu_num = '0;
      cfg_out_num = '0;
      cfg_bias = '0;
      in_valid = 1'b0;
      in_data = '0;
      wb_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", int'(wb_valid), 0);
      chk("rst_data", int'(wb_data), 0);
      chk("rst_stall", int'(stall), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(op_done), 0);
      chk("rst_ovf", int'(err_ovf), 0);
      rst_n = 1'b1;
      tick();

      // basic: bias 10, groups (1,2,3) and (4,5,6)
      wb_ready = 1'b1;
      start(3, 2, 10);
      chk("basic_busy", int'(busy), 1);
      for (int i = 1; i <= 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         tick();
         if (i == 2) chk("basic_nopush", int'(wb_valid), 0);
         if (i == 3) chk("basic_out0", $signed(wb_data), 16);
         if (i == 4) chk("basic_popped", int'(wb_valid), 0);
         if (i == 6) chk("basic_out1", $signed(wb_data), 25);
      end
      in_valid = 1'b0;
      tick();
      chk("basic_empty", int'(wb_valid), 0);
      chk("basic_done_early", int'(op_done), 0);
      tick();
      chk("basic_done", int'(op_done), 1);
      chk("basic_busy_done", int'(busy), 0);
      tick();
      chk("basic_done_pulse", int'(op_done), 0);

      // saturation both directions
      start(2, 2, 0);
      in_valid = 1'b1;
      in_data = 16'(30000);
      tick();
      tick();
      chk("sat_pos", $signed(wb_data), 32767);
      in_data = 16'(-30000);
      tick();
      tick();
      chk("sat_neg", $signed(wb_data), -32768);
      in_valid = 1'b0;
      wait_done("sat_done");

      // backpressure and overflow
      wb_ready = 1'b0;
      start(1, 6, 0);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(100 + i);
         tick();
         if (i == 1) chk("bp_stall_lo", int'(stall), 0);
         if (i == 2) chk("bp_stall_hi", int'(stall), 1);
         if (i == 3) chk("bp_ovf_lo", int'(err_ovf), 0);
      end
      in_valid = 1'b0;
      chk("bp_ovf", int'(err_ovf), 1);
      chk("bp_busy", int'(busy), 1);
      tick();
      chk("bp_hold", $signed(wb_data), 100);
      wb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_pop", $signed(wb_data), 100 + k);
         tick();
      end
      chk("bp_empty", int'(wb_valid), 0);
      chk("bp_stall_clr", int'(stall), 0);
      wait_done("bp_done");
      chk("bp_ovf_sticky", int'(err_ovf), 1);

      // full FIFO with simultaneous push and pop
      wb_ready = 1'b0;
      start(1, 6, 0);
      chk("pp_ovf_clr", int'(err_ovf), 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(200 + i);
         tick();
      end
      wb_ready = 1'b1;
      in_data = 16'(204);
      tick();
      chk("pp_ovf0", int'(err_ovf), 0);
      chk("pp_head0", $signed(wb_data), 201);
      chk("pp_stall", int'(stall), 1);
      in_data = 16'(205);
      tick();
      in_valid = 1'b0;
      chk("pp_ovf1", int'(err_ovf), 0);
      for (int k = 0; k < 4; k++) begin
         chk("pp_pop", $signed(wb_data), 202 + k);
         tick();
      end
      chk("pp_empty", int'(wb_valid), 0);
      wait_done("pp_done");

      // reset mid-operation with two entries queued
      wb_ready = 1'b0;
      start(1, 6, 0);
      in_valid = 1'b1;
      in_data = 16'(300);
      tick();
      in_data = 16'(301);
      tick();
      in_valid = 1'b0;
      chk("mr_valid_pre", int'(wb_valid), 1);
      rst_n = 1'b0;
      tick();
      chk("mr_valid", int'(wb_valid), 0);
      chk("mr_data", int'(wb_data), 0);
      chk("mr_busy", int'(busy), 0);
      chk("mr_stall", int'(stall), 0);
      chk("mr_done", int'(op_done), 0);
      rst_n = 1'b1;
      tick();
      wb_ready = 1'b1;
      start(1, 1, 5);
      in_valid = 1'b1;
      in_data = 16'(7);
      tick();
      in_valid = 1'b0;
      chk("mr_new", $signed(wb_data), 12);
      wait_done("mr_done2");

      // out_num of zero completes immediately
      start(3, 0, 0);
      chk("zero_done", int'(op_done), 1);
      chk("zero_busy", int'(busy), 0);
      tick();

      // negative result: ReLU build clamps to zero
      start(1, 1, -50);
      in_valid = 1'b1;
      in_data = 16'(20);
      tick();
      in_valid = 1'b0;
`ifdef YTYDLA_CACC_RELU_EN
      chk("relu_out", $signed(wb_data), 0);
`else
      chk("relu_out", $signed(wb_data), -30);
`endif
      wait_done("relu_done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
